mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 27 ++
 rtl/mem_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_mem_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared op encodings, truth constants and state/source types for mem_ctrl
package mem_ctrl_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LW  = 6'd3;
  localparam logic [5:0] OP_LBU = 6'd4;
  localparam logic [5:0] OP_LHU = 6'd5;
  localparam logic [5:0] OP_SB  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;
  localparam logic [5:0] OP_SW  = 6'd8;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} state_e;
  typedef enum logic [1:0] {SRC_FETCH, SRC_LOAD, SRC_STORE} src_e;

  function automatic logic [2:0] op_bytes(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 3'd1;
      OP_LH, OP_LHU, OP_SH: return 3'd2;
      default:              return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM arbiter for fetch, load and committed-store traffic
// One request at a time; RAM read data arrives one cycle after its address.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        io_buffer_full,
  input  logic        if_sgn,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_inst,
  input  logic        load_store_sgn,
  input  logic [5:0]  load_store_op,
  input  logic [31:0] load_store_addr,
  output logic        mem_valid,
  output logic [31:0] mem_res,
  input  logic        store_sgn,
  input  logic [5:0]  store_op,
  input  logic [31:0] store_addr,
  input  logic [31:0] store_data,
  output logic        finish_store,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  state_e      state_q, state_d;
  src_e        src_q, src_d;
  logic [2:0]  cnt_q, cnt_d, nb_q, nb_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d, data_q, data_d, buf_q, buf_d;
  logic [31:0] mem_a_q, mem_a_d, if_inst_q, if_inst_d, mem_res_q, mem_res_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        if_valid_q, if_valid_d, mem_valid_q, mem_valid_d, finish_q, finish_d;
  logic [2:0]  nxt;
  logic [1:0]  rd_idx;
  logic        io_block, pulse_q;

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [5:0] op);
    case (op)
      OP_LB:   return {{24{w[7]}}, w[7:0]};
      OP_LBU:  return {24'h0, w[7:0]};
      OP_LH:   return {{16{w[15]}}, w[15:0]};
      OP_LHU:  return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  assign nxt      = cnt_q + 3'd1;
  assign rd_idx   = cnt_q[1:0] - 2'd1;
  assign io_block = (addr_q[17:16] == 2'b11) && io_buffer_full;
  // No new request is taken while a done pulse is showing, so a requester
  // that drops its sgn on seeing the pulse is never accepted twice.
  assign pulse_q  = if_valid_q | mem_valid_q | finish_q;

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    cnt_d       = cnt_q;
    nb_d        = nb_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    buf_d       = buf_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    if_inst_d   = if_inst_q;
    mem_res_d   = mem_res_q;
    if_valid_d  = if_valid_q;
    mem_valid_d = mem_valid_q;
    finish_d    = finish_q;
    if (rdy == TRUE) begin
      if_valid_d  = FALSE;
      mem_valid_d = FALSE;
      finish_d    = FALSE;
      case (state_q)
        ST_IDLE: if (!pulse_q) begin
          cnt_d = 3'd0;
          if (store_sgn) begin
            state_d    = ST_WRITE;
            src_d      = SRC_STORE;
            nb_d       = op_bytes(store_op);
            op_d       = store_op;
            addr_d     = store_addr;
            data_d     = store_data;
            mem_a_d    = store_addr;
            mem_dout_d = store_data[7:0];
          end else if (!rollback && load_store_sgn) begin
            state_d = ST_READ;
            src_d   = SRC_LOAD;
            nb_d    = op_bytes(load_store_op);
            op_d    = load_store_op;
            addr_d  = load_store_addr;
            mem_a_d = load_store_addr;
          end else if (!rollback && if_sgn) begin
            state_d = ST_READ;
            src_d   = SRC_FETCH;
            nb_d    = 3'd4;
            op_d    = OP_LW;
            addr_d  = if_addr;
            mem_a_d = if_addr;
          end
        end
        ST_READ: if (rollback) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else begin
          // cnt_q counts addresses already issued; byte cnt_q-1 is on mem_din now.
          if (cnt_q != 3'd0) buf_d[{rd_idx, 3'b000} +: 8] = mem_din;
          if (cnt_q == nb_q) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
            if (src_q == SRC_FETCH) begin
              if_valid_d = TRUE;
              if_inst_d  = buf_d;
            end else begin
              mem_valid_d = TRUE;
              mem_res_d   = extend(buf_d, op_q);
            end
          end else begin
            cnt_d = nxt;
            if (nxt < nb_q) mem_a_d = addr_q + {29'd0, nxt};
          end
        end
        ST_WRITE: if (!io_block) begin
          if (nxt == nb_q) begin
            state_d  = ST_IDLE;
            cnt_d    = 3'd0;
            finish_d = TRUE;
          end else begin
            cnt_d      = nxt;
            mem_a_d    = addr_q + {29'd0, nxt};
            mem_dout_d = data_q[{nxt[1:0], 3'b000} +: 8];
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      src_q       <= SRC_FETCH;
      cnt_q       <= 3'd0;
      nb_q        <= 3'd0;
      op_q        <= 6'd0;
      addr_q      <= 32'd0;
      data_q      <= 32'd0;
      buf_q       <= 32'd0;
      mem_a_q     <= 32'd0;
      mem_dout_q  <= 8'd0;
      if_inst_q   <= 32'd0;
      mem_res_q   <= 32'd0;
      if_valid_q  <= FALSE;
      mem_valid_q <= FALSE;
      finish_q    <= FALSE;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      cnt_q       <= cnt_d;
      nb_q        <= nb_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      buf_q       <= buf_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      if_inst_q   <= if_inst_d;
      mem_res_q   <= mem_res_d;
      if_valid_q  <= if_valid_d;
      mem_valid_q <= mem_valid_d;
      finish_q    <= finish_d;
    end
  end

  assign mem_wr       = rdy && (state_q == ST_WRITE) && !io_block;
  assign mem_a        = mem_a_q;
  assign mem_dout     = mem_dout_q;
  assign if_valid     = if_valid_q;
  assign if_inst      = if_inst_q;
  assign mem_valid    = mem_valid_q;
  assign mem_res      = mem_res_q;
  assign finish_store = finish_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed scoreboard bench for mem_ctrl
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1, rollback = 1'b0, io_buffer_full = 1'b0;
  logic        if_sgn = 1'b0, load_store_sgn = 1'b0, store_sgn = 1'b0;
  logic [31:0] if_addr = 32'h0, load_store_addr = 32'h0, store_addr = 32'h0, store_data = 32'h0;
  logic [5:0]  load_store_op = 6'h0, store_op = 6'h0;
  logic [7:0]  mem_din = 8'h0;
  logic        if_valid, mem_valid, finish_store, mem_wr;
  logic [31:0] if_inst, mem_res, mem_a;
  logic [7:0]  mem_dout;

  typedef struct {logic [1:0] kind; logic [31:0] val;} exp_t;
  typedef struct {logic [31:0] a; logic [7:0] d;} wr_t;
  exp_t sq[$];
  wr_t  wq[$];
  int   n_checks = 0, n_fail = 0;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .io_buffer_full(io_buffer_full),
    .if_sgn(if_sgn), .if_addr(if_addr), .if_valid(if_valid), .if_inst(if_inst),
    .load_store_sgn(load_store_sgn), .load_store_op(load_store_op), .load_store_addr(load_store_addr),
    .mem_valid(mem_valid), .mem_res(mem_res),
    .store_sgn(store_sgn), .store_op(store_op), .store_addr(store_addr), .store_data(store_data),
    .finish_store(finish_store), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_byte(input logic [31:0] a);
    case (a)
      32'h100: return 8'h78;
      32'h101: return 8'h56;
      32'h102: return 8'h34;
      32'h103: return 8'h12;
      32'h020: return 8'h80;
      default: return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  always @(posedge clk) mem_din <= model_byte(mem_a);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(output bit pulsed);
    int         np;
    logic [1:0]  kind;
    logic [31:0] val;
    exp_t        e;
    wr_t         w;
    @(negedge clk);
    np     = int'(if_valid) + int'(mem_valid) + int'(finish_store);
    pulsed = (np != 0);
    if (mem_wr) begin
      if (wq.size() == 0) check("write_expected", {31'h0, mem_wr}, 32'h0);
      else begin
        w = wq.pop_front();
        check("wr_addr", mem_a, w.a);
        check("wr_data", {24'h0, mem_dout}, {24'h0, w.d});
      end
    end
    if (pulsed) begin
      check("single_pulse", 32'(np), 32'd1);
      kind = finish_store ? SRC_STORE : (mem_valid ? SRC_LOAD : SRC_FETCH);
      val  = mem_valid ? mem_res : (if_valid ? if_inst : 32'h0);
      if (sq.size() == 0) check("pulse_expected", 32'(np), 32'd0);
      else begin
        e = sq.pop_front();
        check("pulse_src", {30'h0, kind}, {30'h0, e.kind});
        if (e.kind != SRC_STORE) check("pulse_data", val, e.val);
      end
    end
  endtask

  task automatic push_wr(input logic [31:0] addr, input logic [31:0] data, input int nb);
    for (int k = 0; k < nb; k++) wq.push_back('{addr + 32'(k), 8'(data >> (8 * k))});
  endtask

  task automatic do_read(input bit fetch, input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] expv, input int nb, input int exp_lat);
    bit p;
    int lat = 0;
    sq.push_back('{fetch ? SRC_FETCH : SRC_LOAD, expv});
    if (fetch) begin if_sgn = 1'b1; if_addr = addr; end
    else begin load_store_sgn = 1'b1; load_store_op = op; load_store_addr = addr; end
    for (int i = 1; i <= 20; i++) begin
      step(p);
      if (i <= nb) begin
        check("rd_addr", mem_a, addr + 32'(i - 1));
        check("rd_nowr", {31'h0, mem_wr}, 32'h0);
      end
      if (p) begin lat = i; break; end
    end
    if_sgn = 1'b0; load_store_sgn = 1'b0;
    check("rd_latency", 32'(lat), 32'(exp_lat));
    step(p);
  endtask

  task automatic do_write(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input int nb, input int exp_lat);
    bit p;
    int lat = 0;
    push_wr(addr, data, nb);
    sq.push_back('{SRC_STORE, 32'h0});
    store_sgn = 1'b1; store_op = op; store_addr = addr; store_data = data;
    for (int i = 1; i <= 20; i++) begin
      step(p);
      if (i <= nb) check("wr_active", {31'h0, mem_wr}, 32'h1);
      if (p) begin lat = i; break; end
    end
    store_sgn = 1'b0;
    check("wr_latency", 32'(lat), 32'(exp_lat));
    step(p);
  endtask

  initial begin
    bit p;
    int seen, lat;
    @(negedge clk);
    @(negedge clk);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_ctrl", {20'h0, if_valid, mem_valid, finish_store, mem_wr, mem_dout}, 32'h0);
    check("rst_data", if_inst | mem_res, 32'h0);
    rst = 1'b0;
    step(p);

    do_read(1'b0, OP_LW,  32'h100, 32'h12345678, 4, 6);
    do_read(1'b0, OP_LB,  32'h020, 32'hFFFFFF80, 1, 3);
    do_read(1'b0, OP_LBU, 32'h020, 32'h00000080, 1, 3);
    do_read(1'b0, OP_LH,  32'h0D0, 32'hFFFF8B8A, 2, 4);
    do_read(1'b0, OP_LHU, 32'h0D0, 32'h00008B8A, 2, 4);
    do_read(1'b1, OP_LW,  32'hFFFFFFFE, 32'h5B5AA5A4, 4, 6);
    do_write(OP_SH, 32'hFFFFFFFF, 32'h00001234, 2, 3);
    do_write(OP_SB, 32'h00000044, 32'h000000C3, 1, 2);

    // store, load and fetch raised together
    push_wr(32'h200, 32'hDEADBEEF, 4);
    sq.push_back('{SRC_STORE, 32'h0});
    sq.push_back('{SRC_LOAD, 32'hFFFFFF80});
    sq.push_back('{SRC_FETCH, 32'h12345678});
    store_sgn = 1'b1; store_op = OP_SW; store_addr = 32'h200; store_data = 32'hDEADBEEF;
    load_store_sgn = 1'b1; load_store_op = OP_LB; load_store_addr = 32'h20;
    if_sgn = 1'b1; if_addr = 32'h100;
    seen = 0;
    for (int i = 1; i <= 60; i++) begin
      step(p);
      if (i <= 4) check("prio_wr", {31'h0, mem_wr}, 32'h1);
      if (p) begin
        seen++;
        if (seen == 1) check("prio_store_lat", 32'(i), 32'd5);
        if (finish_store) store_sgn = 1'b0;
        if (mem_valid) load_store_sgn = 1'b0;
        if (if_valid) if_sgn = 1'b0;
        if (seen == 3) break;
      end
    end
    check("prio_count", 32'(seen), 32'd3);
    store_sgn = 1'b0; load_store_sgn = 1'b0; if_sgn = 1'b0;
    step(p);

    // IO-space byte held off by a full UART buffer
    push_wr(32'h30000, 32'h000000A5, 1);
    sq.push_back('{SRC_STORE, 32'h0});
    io_buffer_full = 1'b1;
    store_sgn = 1'b1; store_op = OP_SB; store_addr = 32'h30000; store_data = 32'h000000A5;
    for (int i = 1; i <= 3; i++) begin
      step(p);
      check("io_held", {30'h0, mem_wr, p}, 32'h0);
    end
    @(posedge clk);
    #1 io_buffer_full = 1'b0;
    step(p);
    check("io_wr", {31'h0, mem_wr}, 32'h1);
    step(p);
    check("io_finish", {31'h0, finish_store}, 32'h1);
    store_sgn = 1'b0;
    step(p);

    // rdy low for two cycles in the middle of a word store
    push_wr(32'h240, 32'hCAFEF00D, 4);
    sq.push_back('{SRC_STORE, 32'h0});
    store_sgn = 1'b1; store_op = OP_SW; store_addr = 32'h240; store_data = 32'hCAFEF00D;
    step(p);
    @(posedge clk);
    #1 rdy = 1'b0;
    for (int i = 2; i <= 3; i++) begin
      step(p);
      check("frz_wr", {31'h0, mem_wr}, 32'h0);
      check("frz_addr", mem_a, 32'h241);
    end
    @(posedge clk);
    #1 rdy = 1'b1;
    lat = 0;
    for (int i = 4; i <= 20; i++) begin
      step(p);
      if (p) begin lat = i; break; end
    end
    check("frz_latency", 32'(lat), 32'd7);
    store_sgn = 1'b0;
    step(p);

    // rollback held across a whole store: accepted from IDLE and not aborted
    rollback = 1'b1;
    do_write(OP_SW, 32'h280, 32'h01020304, 4, 5);
    rollback = 1'b0;

    // rollback in IDLE delays a load by one cycle
    sq.push_back('{SRC_LOAD, 32'h12345678});
    rollback = 1'b1;
    load_store_sgn = 1'b1; load_store_op = OP_LW; load_store_addr = 32'h100;
    @(posedge clk);
    #1 rollback = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step(p);
      if (p) begin lat = i; break; end
    end
    check("rb_idle_latency", 32'(lat), 32'd7);
    load_store_sgn = 1'b0;
    step(p);

    // rollback in cycle 2 of a fetch, then a load right behind it
    if_sgn = 1'b1; if_addr = 32'h100;
    step(p);
    @(posedge clk);
    #1 rollback = 1'b1;
    @(posedge clk);
    #1 rollback = 1'b0;
    if_sgn = 1'b0;
    sq.push_back('{SRC_LOAD, 32'hFFFFFF80});
    load_store_sgn = 1'b1; load_store_op = OP_LB; load_store_addr = 32'h20;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step(p);
      if (i == 2) check("rb_next_addr", mem_a, 32'h20);
      if (p) begin lat = i; break; end
    end
    check("rb_fetch_latency", 32'(lat), 32'd4);
    load_store_sgn = 1'b0;
    step(p);

    // reset in the middle of a word load
    sq.push_back('{SRC_LOAD, 32'h12345678});
    load_store_sgn = 1'b1; load_store_op = OP_LW; load_store_addr = 32'h100;
    step(p);
    step(p);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_mem_a", mem_a, 32'h0);
    check("midrst_ctrl", {20'h0, if_valid, mem_valid, finish_store, mem_wr, mem_dout}, 32'h0);
    load_store_sgn = 1'b0;
    sq.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step(p);
    do_read(1'b0, OP_LW, 32'h100, 32'h12345678, 4, 6);

    check("sb_drained", 32'(sq.size() + wq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
